// File: rtl/abbuf_feed_ctrl.sv
// abbuf_feed_ctrl: sequences one systolic feed run out of the ab input buffer,
// counts issued words, and shares the buffer's single read port with host
// readback (host has priority; a host access in RUN steals that feed cycle).
module abbuf_feed_ctrl #(
  parameter int ADR_W = 10,
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_start,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_abort,
  input  logic             ff,
  input  logic             host_rreq,
  input  logic [ADR_W-1:0] host_radr,
  output logic             start,
  output logic             sys_running,
  output logic             ren,
  output logic [ADR_W-1:0] abbus_radr,
  output logic             host_rack,
  output logic             host_rvalid,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [LEN_W-1:0] word_cnt
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt_r;
  logic [LEN_W-1:0] cnt_inc_s;
  logic             feed_s;
  logic             issue_s;
  logic             last_s;
  logic             abort_s;
  logic             accept_s;
  logic             ren_s;
  logic             start_r;
  logic             busy_r;
  logic             done_r;
  logic             aborted_r;
  logic             rvalid_r;

  assign cnt_inc_s = cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
  // The feed only drives the array in RUN and only when the host is not
  // stealing the read port this cycle.
  assign feed_s    = (state_r == ST_RUN) & ~host_rreq;
  assign issue_s   = feed_s & ~ff;
  assign last_s    = issue_s & (cnt_inc_s == len_r);
  assign abort_s   = cmd_abort & (state_r != ST_IDLE);
  assign accept_s  = cmd_start & (state_r == ST_IDLE);

  // Read-port ownership: host served in every state except INIT, so start
  // and ren are never asserted together. Gated by rst_n so the port is
  // released immediately while reset is held.
  always_comb begin
    ren_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_RUN, ST_DRAIN, ST_FIN: ren_s = host_rreq & rst_n;
      ST_INIT:                          ren_s = 1'b0;
      default:                          ren_s = 1'b0;
    endcase
  end

  // Run sequencing: abort overrides everything outside IDLE.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (cmd_start) state_nxt_s = ST_INIT;
        else           state_nxt_s = ST_IDLE;
      end
      ST_INIT: begin
        if (cmd_abort)                   state_nxt_s = ST_IDLE;
        else if (len_r == {LEN_W{1'b0}}) state_nxt_s = ST_DRAIN;
        else                             state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (cmd_abort)   state_nxt_s = ST_IDLE;
        else if (last_s) state_nxt_s = ST_DRAIN;
        else             state_nxt_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (cmd_abort) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_FIN;
      end
      ST_FIN:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register plus status outputs decoded from the next state so they
  // leave the block straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      start_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      start_r   <= (state_nxt_s == ST_INIT);
      busy_r    <= (state_nxt_s != ST_IDLE);
      done_r    <= (state_nxt_s == ST_FIN);
      aborted_r <= abort_s;
    end
  end

  // Run length latch and issued-word counter; the abort cycle does not count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r <= {LEN_W{1'b0}};
      cnt_r <= {LEN_W{1'b0}};
    end else if (accept_s) begin
      len_r <= cmd_len;
      cnt_r <= {LEN_W{1'b0}};
    end else if (issue_s && !cmd_abort) begin
      cnt_r <= cnt_inc_s;
    end
  end

  // Host data appears on ab_in one cycle after the read, matching the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rvalid_r <= 1'b0;
    else        rvalid_r <= ren_s;
  end

  assign start       = start_r;
  assign sys_running = feed_s;
  assign ren         = ren_s;
  assign host_rack   = ren_s;
  assign abbus_radr  = ren_s ? host_radr : {ADR_W{1'b0}};
  assign host_rvalid = rvalid_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign aborted     = aborted_r;
  assign word_cnt    = cnt_r;

endmodule

// File: tb/tb_abbuf_feed_ctrl.sv
// Testbench for abbuf_feed_ctrl: a directed vector table, hand-written
// multi-cycle sequences, and random traffic checked against a run-level model.
module tb_abbuf_feed_ctrl;

  localparam int ADR_W = 10;
  localparam int LEN_W = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_start;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_abort;
  logic             ff;
  logic             host_rreq;
  logic [ADR_W-1:0] host_radr;
  logic             start, sys_running, ren, host_rack, host_rvalid;
  logic             busy, done, aborted;
  logic [ADR_W-1:0] abbus_radr;
  logic [LEN_W-1:0] word_cnt;

  abbuf_feed_ctrl #(.ADR_W(ADR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_len(cmd_len),
    .cmd_abort(cmd_abort), .ff(ff), .host_rreq(host_rreq), .host_radr(host_radr),
    .start(start), .sys_running(sys_running), .ren(ren), .abbus_radr(abbus_radr),
    .host_rack(host_rack), .host_rvalid(host_rvalid), .busy(busy), .done(done),
    .aborted(aborted), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    int         len;
    logic       ab;
    logic       ff;
    logic       rq;
    logic [9:0] radr;
    logic       e_start;
    logic       e_sr;
    logic       e_ren;
    logic [9:0] e_radr;
    logic       e_busy;
    logic       e_done;
    logic       e_abt;
    int         e_cnt;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  // run-level reference model
  bit m_active, m_start_cyc, m_abort_pulse, m_prev_ren;
  int m_tail, m_len, m_cnt;

  // observation counters for sequence-level checks
  int o_sr, o_issue, o_done, o_abt, o_ren, o_rvalid, o_hit, o_maxcnt;

  function automatic vec_t mk(logic st, int len, logic ab, logic f, logic rq,
                              logic [9:0] radr, logic es, logic esr, logic er,
                              logic [9:0] era, logic eb, logic ed, logic ea, int ec);
    vec_t v;
    v.st = st; v.len = len; v.ab = ab; v.ff = f; v.rq = rq; v.radr = radr;
    v.e_start = es; v.e_sr = esr; v.e_ren = er; v.e_radr = era;
    v.e_busy = eb; v.e_done = ed; v.e_abt = ea; v.e_cnt = ec;
    return v;
  endfunction

  function automatic vec_t mkin(logic st, int len, logic ab, logic f, logic rq, logic [9:0] radr);
    return mk(st, len, ab, f, rq, radr, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_start_cyc = 1'b0; m_abort_pulse = 1'b0; m_prev_ren = 1'b0;
    m_tail = 0; m_len = 0; m_cnt = 0;
  endtask

  task automatic clr_obs();
    o_sr = 0; o_issue = 0; o_done = 0; o_abt = 0; o_ren = 0; o_rvalid = 0; o_hit = 0; o_maxcnt = 0;
  endtask

  // One clock cycle: drive inputs, check at negedge, advance model at posedge.
  task automatic step(input vec_t v, input bit use_tab);
    bit feeding, e_ren, e_sr, issue;
    cmd_start = v.st; cmd_len = v.len[9:0]; cmd_abort = v.ab;
    ff = v.ff; host_rreq = v.rq; host_radr = v.radr;
    @(negedge clk);
    feeding = m_active && !m_start_cyc && (m_tail == 0);
    e_ren   = v.rq && !m_start_cyc;
    e_sr    = feeding && !v.rq;
    chk("start",       start,       m_start_cyc);
    chk("sys_running", sys_running, e_sr);
    chk("ren",         ren,         e_ren);
    chk("host_rack",   host_rack,   e_ren);
    chk("abbus_radr",  abbus_radr,  e_ren ? v.radr : 10'd0);
    chk("host_rvalid", host_rvalid, m_prev_ren);
    chk("busy",        busy,        m_active);
    chk("done",        done,        m_active && (m_tail == 1));
    chk("aborted",     aborted,     m_abort_pulse);
    chk("word_cnt",    word_cnt,    m_cnt);
    if (use_tab) begin
      chk("tab_start",   start,       v.e_start);
      chk("tab_sysrun",  sys_running, v.e_sr);
      chk("tab_ren",     ren,         v.e_ren);
      chk("tab_radr",    abbus_radr,  v.e_radr);
      chk("tab_busy",    busy,        v.e_busy);
      chk("tab_done",    done,        v.e_done);
      chk("tab_aborted", aborted,     v.e_abt);
      chk("tab_cnt",     word_cnt,    v.e_cnt);
    end
    o_sr     += int'(sys_running);
    o_issue  += int'(sys_running && !ff);
    o_done   += int'(done);
    o_abt    += int'(aborted);
    o_ren    += int'(ren);
    o_rvalid += int'(host_rvalid);
    o_hit    += int'(ren && (abbus_radr == 10'h1F0));
    if (int'(word_cnt) > o_maxcnt) o_maxcnt = int'(word_cnt);
    @(posedge clk);
    issue = e_sr && !v.ff;
    m_prev_ren    = e_ren;
    m_abort_pulse = m_active && v.ab;
    if (!m_active) begin
      if (v.st) begin
        m_active = 1'b1; m_start_cyc = 1'b1; m_len = v.len; m_cnt = 0; m_tail = 0;
      end
    end else if (v.ab) begin
      m_active = 1'b0; m_start_cyc = 1'b0; m_tail = 0;
    end else if (m_start_cyc) begin
      m_start_cyc = 1'b0;
      if (m_len == 0) m_tail = 2;
    end else if (m_tail > 0) begin
      m_tail--;
      if (m_tail == 0) m_active = 1'b0;
    end else if (issue) begin
      m_cnt++;
      if (m_cnt == m_len) m_tail = 2;
    end
    #1;
  endtask

  // Run idle cycles until the model reports the run finished, bounded.
  task automatic finish_run(input string nm);
    for (int k = 0; k < 60 && m_active; k++) step(mkin(1'b0, 0, 1'b0, 1'b0, 1'b0, 10'd0), 1'b0);
    step(mkin(1'b0, 0, 1'b0, 1'b0, 1'b0, 10'd0), 1'b0);
    chk(nm, busy, 1'b0);
  endtask

  vec_t tab[26];

  initial begin
    tab[0]  = mk(1, 4, 0, 0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 0, 0, 0);
    tab[1]  = mk(0, 0, 0, 0, 0, 10'h000, 1, 0, 0, 10'h000, 1, 0, 0, 0);
    tab[2]  = mk(0, 0, 0, 0, 0, 10'h000, 0, 1, 0, 10'h000, 1, 0, 0, 0);
    tab[3]  = mk(0, 0, 0, 0, 0, 10'h000, 0, 1, 0, 10'h000, 1, 0, 0, 1);
    tab[4]  = mk(0, 0, 0, 0, 0, 10'h000, 0, 1, 0, 10'h000, 1, 0, 0, 2);
    tab[5]  = mk(0, 0, 0, 0, 0, 10'h000, 0, 1, 0, 10'h000, 1, 0, 0, 3);
    tab[6]  = mk(0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 10'h000, 1, 0, 0, 4);
    tab[7]  = mk(0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 10'h000, 1, 1, 0, 4);
    tab[8]  = mk(0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 0, 0, 4);
    tab[9]  = mk(1, 0, 0, 0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 0, 0, 4);
    tab[10] = mk(1, 7, 0, 0, 0, 10'h000, 1, 0, 0, 10'h000, 1, 0, 0, 0);
    tab[11] = mk(1, 9, 0, 0, 0, 10'h000, 0, 0, 0, 10'h000, 1, 0, 0, 0);
    tab[12] = mk(0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 10'h000, 1, 1, 0, 0);
    tab[13] = mk(0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 0, 0, 0);
    tab[14] = mk(1, 3, 0, 0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 0, 0, 0);
    tab[15] = mk(0, 0, 0, 0, 0, 10'h000, 1, 0, 0, 10'h000, 1, 0, 0, 0);
    tab[16] = mk(0, 0, 1, 0, 0, 10'h000, 0, 1, 0, 10'h000, 1, 0, 0, 0);
    tab[17] = mk(0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 0, 1, 0);
    tab[18] = mk(0, 0, 0, 0, 1, 10'h155, 0, 0, 1, 10'h155, 0, 0, 0, 0);
    tab[19] = mk(1, 1, 0, 0, 1, 10'h0AA, 0, 0, 1, 10'h0AA, 0, 0, 0, 0);
    tab[20] = mk(0, 0, 0, 0, 1, 10'h0AA, 1, 0, 0, 10'h000, 1, 0, 0, 0);
    tab[21] = mk(0, 0, 0, 0, 1, 10'h0AA, 0, 0, 1, 10'h0AA, 1, 0, 0, 0);
    tab[22] = mk(0, 0, 0, 0, 0, 10'h000, 0, 1, 0, 10'h000, 1, 0, 0, 0);
    tab[23] = mk(0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 10'h000, 1, 0, 0, 1);
    tab[24] = mk(0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 10'h000, 1, 1, 0, 1);
    tab[25] = mk(0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 0, 0, 1);

    // reset state
    rst_n = 1'b0; cmd_start = 1'b0; cmd_len = '0; cmd_abort = 1'b0;
    ff = 1'b0; host_rreq = 1'b0; host_radr = '0;
    model_reset();
    #3;
    chk("rst_start", start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", word_cnt, 10'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // directed table
    for (int i = 0; i < 26; i++) step(tab[i], 1'b1);

    // stall: ff during 2nd and 3rd RUN cycles
    clr_obs();
    step(mkin(1'b1, 5, 1'b0, 1'b0, 1'b0, 10'd0), 1'b0);
    for (int k = 1; k < 40 && m_active; k++)
      step(mkin(1'b0, 0, 1'b0, (k == 3 || k == 4), 1'b0, 10'd0), 1'b0);
    step(mkin(1'b0, 0, 1'b0, 1'b0, 1'b0, 10'd0), 1'b0);
    chk("stall_sr_cycles", o_sr, 7);
    chk("stall_issues", o_issue, 5);
    chk("stall_done_once", o_done, 1);
    chk("stall_maxcnt", o_maxcnt, 5);
    chk("stall_idle", busy, 1'b0);

    // host steal of two RUN cycles
    clr_obs();
    step(mkin(1'b1, 8, 1'b0, 1'b0, 1'b0, 10'd0), 1'b0);
    for (int k = 1; k < 40 && m_active; k++)
      step(mkin(1'b0, 0, 1'b0, 1'b0, (k == 4 || k == 5), 10'h1F0), 1'b0);
    step(mkin(1'b0, 0, 1'b0, 1'b0, 1'b0, 10'd0), 1'b0);
    chk("steal_ren", o_ren, 2);
    chk("steal_radr_hits", o_hit, 2);
    chk("steal_rvalid", o_rvalid, 2);
    chk("steal_issues", o_issue, 8);
    chk("steal_cnt", word_cnt, 10'd8);
    chk("steal_done_once", o_done, 1);

    // abort after three issues
    clr_obs();
    step(mkin(1'b1, 10, 1'b0, 1'b0, 1'b0, 10'd0), 1'b0);
    for (int k = 1; k < 30 && o_issue < 3; k++)
      step(mkin(1'b0, 0, 1'b0, 1'b0, 1'b0, 10'd0), 1'b0);
    step(mkin(1'b0, 0, 1'b1, 1'b0, 1'b0, 10'd0), 1'b0);
    step(mkin(1'b0, 0, 1'b0, 1'b0, 1'b0, 10'd0), 1'b0);
    chk("abort_pulse", o_abt, 1);
    chk("abort_no_done", o_done, 0);
    chk("abort_cnt", word_cnt, 10'd3);
    chk("abort_sr", sys_running, 1'b0);
    chk("abort_busy", busy, 1'b0);

    // asynchronous reset in mid-run, with a host read just before it
    step(mkin(1'b1, 6, 1'b0, 1'b0, 1'b0, 10'd0), 1'b0);
    step(mkin(1'b0, 0, 1'b0, 1'b0, 1'b0, 10'd0), 1'b0);
    step(mkin(1'b0, 0, 1'b0, 1'b0, 1'b0, 10'd0), 1'b0);
    step(mkin(1'b0, 0, 1'b0, 1'b0, 1'b1, 10'h0F0), 1'b0);
    host_rreq = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_start", start, 1'b0);
    chk("mrst_sr", sys_running, 1'b0);
    chk("mrst_ren", ren, 1'b0);
    chk("mrst_rack", host_rack, 1'b0);
    chk("mrst_radr", abbus_radr, 10'd0);
    chk("mrst_rvalid", host_rvalid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_aborted", aborted, 1'b0);
    chk("mrst_cnt", word_cnt, 10'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    clr_obs();
    step(mkin(1'b1, 2, 1'b0, 1'b0, 1'b0, 10'd0), 1'b0);
    finish_run("post_rst_idle");
    chk("post_rst_done", o_done, 1);
    chk("post_rst_abt", o_abt, 0);
    chk("post_rst_cnt", word_cnt, 10'd2);

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      vec_t v;
      v = mkin(($urandom % 8) == 0, int'($urandom_range(0, 12)), ($urandom % 40) == 0,
               ($urandom % 4) == 0, ($urandom % 5) == 0, 10'($urandom));
      step(v, 1'b0);
    end
    finish_run("rand_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
